// File: rtl/rgb_scan_ctrl_if.sv
// Operand/response bus between the scan sequencer and the RGB indicator datapath.
// The master side is the sequencer; the slave side is whatever drives start/pause and the datapath.
interface rgb_scan_ctrl_if;
  logic       start;
  logic       pause;
  logic       r_in;
  logic       g_in;
  logic       b_in;
  logic [1:0] a_out;
  logic [1:0] b_out;
  logic       busy;
  logic       done;
  logic       log_valid;
  logic [3:0] log_idx;
  logic [2:0] log_rgb;
  logic [4:0] r_cnt;
  logic [4:0] g_cnt;
  logic [4:0] b_cnt;

  modport master (
    input  start, pause, r_in, g_in, b_in,
    output a_out, b_out, busy, done, log_valid, log_idx, log_rgb, r_cnt, g_cnt, b_cnt
  );

  modport slave (
    output start, pause, r_in, g_in, b_in,
    input  a_out, b_out, busy, done, log_valid, log_idx, log_rgb, r_cnt, g_cnt, b_cnt
  );
endinterface

// File: rtl/rgb_scan_ctrl.sv
// Walks all 16 {a,b} operand combinations, holds each for DWELL cycles, samples R/G/B
// and publishes a log record plus per-colour hit counts. All outputs are registered.
module rgb_scan_ctrl #(
  parameter int DWELL   = 4,
  parameter int DWELL_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  rgb_scan_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_CAPTURE,
    S_DONE
  } state_e;

  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);

  state_e               state_q, state_d;
  logic [3:0]           idx_q, idx_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic [3:0]           ab_q, ab_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 log_valid_q, log_valid_d;
  logic [3:0]           log_idx_q, log_idx_d;
  logic [2:0]           log_rgb_q, log_rgb_d;
  logic [4:0]           r_cnt_q, r_cnt_d;
  logic [4:0]           g_cnt_q, g_cnt_d;
  logic [4:0]           b_cnt_q, b_cnt_d;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    dwell_d     = dwell_q;
    log_valid_d = 1'b0;
    log_idx_d   = log_idx_q;
    log_rgb_d   = log_rgb_q;
    r_cnt_d     = r_cnt_q;
    g_cnt_d     = g_cnt_q;
    b_cnt_d     = b_cnt_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_DRIVE;
          idx_d   = 4'd0;
          dwell_d = '0;
          r_cnt_d = 5'd0;
          g_cnt_d = 5'd0;
          b_cnt_d = 5'd0;
        end
      end
      S_DRIVE: begin
        if (!bus.pause) begin
          if (dwell_q == DWELL_LAST) begin
            state_d = S_CAPTURE;
          end else begin
            dwell_d = dwell_q + 1'b1;
          end
        end
      end
      S_CAPTURE: begin
        log_valid_d = 1'b1;
        log_idx_d   = idx_q;
        log_rgb_d   = {bus.r_in, bus.g_in, bus.b_in};
        r_cnt_d     = r_cnt_q + 5'(bus.r_in);
        g_cnt_d     = g_cnt_q + 5'(bus.g_in);
        b_cnt_d     = b_cnt_q + 5'(bus.b_in);
        if (idx_q == 4'd15) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DRIVE;
          idx_d   = idx_q + 4'd1;
          dwell_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so they are derived from the state being entered.
    busy_d = (state_d == S_DRIVE) || (state_d == S_CAPTURE);
    done_d = (state_d == S_DONE);
    ab_d   = (state_d == S_IDLE) ? 4'd0 : idx_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= 4'd0;
      dwell_q     <= '0;
      ab_q        <= 4'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      log_valid_q <= 1'b0;
      log_idx_q   <= 4'd0;
      log_rgb_q   <= 3'd0;
      r_cnt_q     <= 5'd0;
      g_cnt_q     <= 5'd0;
      b_cnt_q     <= 5'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      dwell_q     <= dwell_d;
      ab_q        <= ab_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      log_valid_q <= log_valid_d;
      log_idx_q   <= log_idx_d;
      log_rgb_q   <= log_rgb_d;
      r_cnt_q     <= r_cnt_d;
      g_cnt_q     <= g_cnt_d;
      b_cnt_q     <= b_cnt_d;
    end
  end

  assign bus.a_out     = ab_q[3:2];
  assign bus.b_out     = ab_q[1:0];
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.log_valid = log_valid_q;
  assign bus.log_idx   = log_idx_q;
  assign bus.log_rgb   = log_rgb_q;
  assign bus.r_cnt     = r_cnt_q;
  assign bus.g_cnt     = g_cnt_q;
  assign bus.b_cnt     = b_cnt_q;

endmodule

// File: tb/tb_rgb_scan_ctrl.sv
// Bench for rgb_scan_ctrl: reset/idle vector table, directed scans and randomized scans
// with a datapath truth table, checked against an arithmetic timeline of the scan.
module tb_rgb_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start_drv;
  logic       pause_drv;
  int         sel;
  logic [2:0] lut [16];

  int checks = 0;
  int errors = 0;

  rgb_scan_ctrl_if if4 ();
  rgb_scan_ctrl_if if1 ();

  rgb_scan_ctrl #(.DWELL(4), .DWELL_W(8)) dut4 (.clk(clk), .rst(rst), .bus(if4));
  rgb_scan_ctrl #(.DWELL(1), .DWELL_W(3)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  // Datapath stand-in: R/G/B are a pure function of the operands currently driven.
  assign if4.start = start_drv & (sel == 0);
  assign if4.pause = pause_drv & (sel == 0);
  assign if4.r_in  = lut[{if4.a_out, if4.b_out}][2];
  assign if4.g_in  = lut[{if4.a_out, if4.b_out}][1];
  assign if4.b_in  = lut[{if4.a_out, if4.b_out}][0];
  assign if1.start = start_drv & (sel == 1);
  assign if1.pause = pause_drv & (sel == 1);
  assign if1.r_in  = lut[{if1.a_out, if1.b_out}][2];
  assign if1.g_in  = lut[{if1.a_out, if1.b_out}][1];
  assign if1.b_in  = lut[{if1.a_out, if1.b_out}][0];

  logic       o_busy, o_done, o_lv;
  logic [3:0] o_ab, o_idx;
  logic [2:0] o_rgb;
  logic [4:0] o_r, o_g, o_b;

  always_comb begin
    if (sel == 0) begin
      o_busy = if4.busy; o_done = if4.done; o_lv = if4.log_valid;
      o_ab = {if4.a_out, if4.b_out}; o_idx = if4.log_idx; o_rgb = if4.log_rgb;
      o_r = if4.r_cnt; o_g = if4.g_cnt; o_b = if4.b_cnt;
    end else begin
      o_busy = if1.busy; o_done = if1.done; o_lv = if1.log_valid;
      o_ab = {if1.a_out, if1.b_out}; o_idx = if1.log_idx; o_rgb = if1.log_rgb;
      o_r = if1.r_cnt; o_g = if1.g_cnt; o_b = if1.b_cnt;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".busy"}, 32'(o_busy), 0);
    chk({tag, ".done"}, 32'(o_done), 0);
    chk({tag, ".log_valid"}, 32'(o_lv), 0);
    chk({tag, ".ab"}, 32'(o_ab), 0);
    chk({tag, ".log_idx"}, 32'(o_idx), 0);
    chk({tag, ".log_rgb"}, 32'(o_rgb), 0);
    chk({tag, ".cnt"}, {o_r, o_g, o_b}, 0);
  endtask

  // Expected timeline: cycle t counts from the first cycle after the start-accepting edge.
  // Combination m is logged at t=(m+1)*(d+1), shifted by plen if the pause hit combination <= m.
  task automatic run_scan(input int d, input int pk, input int pj, input int plen, input int ts);
    int per, t0, tdone, te, s, exp_m;
    logic exp_lv;
    logic [4:0] er, eg, eb;
    per = d + 1;
    t0 = pk * per + pj;
    tdone = 16 * per + plen;
    er = 0; eg = 0; eb = 0;
    for (int i = 0; i < 16; i++) begin
      er += 5'(lut[i][2]);
      eg += 5'(lut[i][1]);
      eb += 5'(lut[i][0]);
    end
    start_drv = 1'b1;
    pause_drv = 1'b0;
    tick();
    start_drv = 1'b0;
    chk("cnt_cleared", {o_r, o_g, o_b}, 0);
    for (int t = 0; t <= tdone + 2; t++) begin
      exp_lv = 1'b0;
      exp_m = 0;
      for (int m = 0; m < 16; m++) begin
        s = (m + 1) * per + ((plen > 0 && m >= pk) ? plen : 0);
        if (s == t) begin
          exp_lv = 1'b1;
          exp_m = m;
        end
      end
      te = (t < t0) ? t : ((t < t0 + plen) ? t0 : t - plen);
      chk("log_valid", 32'(o_lv), 32'(exp_lv));
      if (exp_lv) begin
        chk("log_idx", 32'(o_idx), 32'(exp_m));
        chk("log_rgb", 32'(o_rgb), 32'(lut[exp_m]));
      end
      chk("operands", 32'(o_ab), (t >= tdone) ? 15 : te / per);
      chk("busy", 32'(o_busy), 32'(t < tdone));
      chk("done", 32'(o_done), 32'(t >= tdone));
      if (t == tdone || t == tdone + 2) begin
        chk("r_cnt", 32'(o_r), 32'(er));
        chk("g_cnt", 32'(o_g), 32'(eg));
        chk("b_cnt", 32'(o_b), 32'(eb));
      end
      pause_drv = (plen > 0 && t >= t0 && t < t0 + plen);
      start_drv = (t == ts);
      tick();
    end
    start_drv = 1'b0;
    pause_drv = 1'b0;
  endtask

  typedef struct {
    logic       rst;
    logic       start;
    logic       pause;
    logic       busy;
    logic       done;
    logic       lv;
    logic [3:0] ab;
  } vec_t;

  vec_t vtab [15];

  initial begin
    int tdone_r, pk, pj, pl, ts;
    rst = 1'b1;
    start_drv = 1'b0;
    pause_drv = 1'b0;
    sel = 0;
    for (int i = 0; i < 16; i++) lut[i] = 3'd0;

    // Reset, ten idle cycles, start together with pause, then reset mid-DRIVE.
    vtab[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    vtab[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    for (int i = 2; i < 12; i++) vtab[i] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    vtab[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0};
    vtab[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0};
    vtab[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    for (int i = 0; i < 15; i++) begin
      rst = vtab[i].rst;
      start_drv = vtab[i].start;
      pause_drv = vtab[i].pause;
      tick();
      chk("vec.busy", 32'(o_busy), 32'(vtab[i].busy));
      chk("vec.done", 32'(o_done), 32'(vtab[i].done));
      chk("vec.log_valid", 32'(o_lv), 32'(vtab[i].lv));
      chk("vec.ab", 32'(o_ab), 32'(vtab[i].ab));
      chk("vec.cnt", {o_r, o_g, o_b}, 0);
    end
    rst = 1'b0;
    start_drv = 1'b0;
    pause_drv = 1'b0;
    tick();

    // R always on, G always off, B follows a[0].
    for (int i = 0; i < 16; i++) lut[i] = {1'b1, 1'b0, 1'(i >> 2)};
    run_scan(4, 0, 0, 0, -1);
    run_scan(4, 5, 1, 7, -1);
    run_scan(4, 0, 0, 0, 9 * 5 + 2);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 16; i++) lut[i] = 3'($urandom_range(0, 7));
      pk = $urandom_range(0, 15);
      pj = $urandom_range(0, 3);
      pl = $urandom_range(0, 9);
      tdone_r = 16 * 5 + pl;
      ts = (r % 2 == 0) ? $urandom_range(0, tdone_r - 1) : -1;
      run_scan(4, pk, pj, pl, ts);
    end

    // Reset landing on the CAPTURE cycle of combination 3.
    start_drv = 1'b1;
    tick();
    start_drv = 1'b0;
    for (int t = 0; t < 3 * 5 + 4; t++) tick();
    chk("cap3.ab", 32'(o_ab), 3);
    chk("cap3.busy", 32'(o_busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_outputs("rst_cap");
    tick();
    chk_reset_outputs("rst_cap_after");

    sel = 1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_outputs("d1_reset");
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 16; i++) lut[i] = 3'($urandom_range(0, 7));
      run_scan(1, 0, 0, 0, -1);
    end
    run_scan(1, 6, 0, 3, 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, errors=%0d", errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rgb_scan_ctrl.md
Name: rgb_scan_ctrl

Overview:
- Sequencer for the 2-bit-operand RGB indicator datapath (inputs a[1:0], b[1:0]; outputs R, G, B).
- On start, drives all 16 operand combinations in order onto the datapath. Each combination is held for a programmable dwell time, then the R/G/B response is sampled and published as a log record.
- Keeps per-colour hit counts, so one run gives a self-check signature for the board or the bench.

Parameters:
- DWELL, 4, number of cycles each combination is held before sampling; legal range 1..255.
- DWELL_W, 8, width of the dwell counter; must satisfy DWELL <= 2**DWELL_W-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  begin a scan; sampled only in IDLE or DONE.
- pause  in  1  freezes the dwell counter while in DRIVE.
- r_in  in  1  datapath R output.
- g_in  in  1  datapath G output.
- b_in  in  1  datapath B output.
- a_out  out  2  operand a to datapath.
- b_out  out  2  operand b to datapath.
- busy  out  1  high in DRIVE and CAPTURE.
- done  out  1  high in DONE.
- log_valid  out  1  one-cycle strobe; a log record is valid.
- log_idx  out  4  combination index of the record, {a,b}.
- log_rgb  out  3  sampled {R,G,B}.
- r_cnt  out  5  number of combinations with R=1 (0..16).
- g_cnt  out  5  number of combinations with G=1 (0..16).
- b_cnt  out  5  number of combinations with B=1 (0..16).

Behaviour:
- One clock domain; reset is synchronous and active-high. All outputs are registered.
- rst=1 at an edge:
  - state=IDLE; idx=0; dwell counter=0.
  - a_out=b_out=0; busy=done=log_valid=0; log_idx=0; log_rgb=0; all counts 0.
  - rst overrides every other input, including mid-scan.
- FSM states: IDLE, DRIVE, CAPTURE, DONE.
- IDLE:
  - a_out=b_out=0.
  - start=1 -> DRIVE with idx=0, dwell=0; counts cleared to 0.
- DRIVE:
  - a_out=idx[3:2], b_out=idx[1:0].
  - With pause=0, dwell increments each cycle. When dwell==DWELL-1 and pause=0 -> CAPTURE.
  - With pause=1, dwell holds and the state holds.
- CAPTURE (exactly one cycle):
  - a_out/b_out unchanged.
  - At the closing edge: log_idx<=idx, log_rgb<={r_in,g_in,b_in}, log_valid<=1; each count increments if its input is 1.
  - If idx==15 -> DONE, else idx<=idx+1, dwell<=0 -> DRIVE.
  - pause is ignored in CAPTURE.
- log_valid is high only in the cycle after CAPTURE; log_idx and log_rgb hold their value until the next record.
- DONE:
  - done=1; a_out/b_out hold combination 15; counts hold.
  - start=1 -> DRIVE with idx=0, counts cleared, done<=0.
- start is ignored while busy. start and pause together in IDLE or DONE: the scan starts, and pause takes effect from the first DRIVE cycle.
- Timing:
  - Each combination takes DWELL+1 cycles.
  - DONE is entered 16*(DWELL+1) edges after the edge that accepted start.
  - The last log_valid coincides with the first DONE cycle.
- idx never wraps within a run; it is reset to 0 only by start or rst.
- Count width: 5 bits, saturation not required (maximum 16).

Test Plan:
- Reset, then idle for 10 cycles -> a_out=b_out=0, busy=done=log_valid=0, all counts 0.
- DWELL=4; bench model r_in=1, g_in=0, b_in=a_out[0]; pulse start ->
  - 16 log_valid strobes, 5 cycles apart, log_idx 0..15 in order;
  - done rises 80 edges after start; r_cnt=16, g_cnt=0, b_cnt=8.
- Same run with pause held for 7 cycles during idx=5 DRIVE -> done delayed by exactly 7 cycles; log contents identical.
- start pulsed at idx=9 -> no restart, no extra strobe. start pulsed in DONE -> counts clear the next cycle and a new scan begins at idx=0.
- rst asserted during CAPTURE of idx=3 -> next cycle IDLE, all outputs at reset values, no log_valid.
- DWELL=1 -> strobes every 2 cycles; done 32 edges after start; log_rgb matches {r_in,g_in,b_in} for each idx.
